mmul_parallel_seq_fsm: RTL and testbench
========================================

Name: mmul_parallel_seq_fsm

Overview:
- Parametrised multi-channel job sequencer; successor to the single-loop MMUL_PARALLEL control path.
- Runs NB_ITER iterations of a job. Each iteration issues one request per stream channel (N_IN sources plus N_OUT sinks), starts the engine, then waits for engine and stream completion.
- Per-channel base/stride address generation is built in; the uloop is not needed for linear strides.
- Sits between hwpe_ctrl_slave (start/clear/params) and the streamer/engine.

Parameters:
- N_IN, 2, number of source stream channels.
- N_OUT, 1, number of sink stream channels (N_CH = N_IN+N_OUT, must be ≥1).
- ADDR_W, 32, address width.
- ITER_W, 16, iteration counter width.
- LEN_W, 16, per-request transfer length width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- clear_i  in  1  synchronous soft clear from slave.
- start_i  in  1  job trigger pulse.
- nb_iter_i  in  ITER_W  iteration count (0 = empty job).
- len_i  in  LEN_W  transfer length per request.
- base_i  in  N_CH×ADDR_W  per-channel base address (sources index 0..N_IN-1, sinks follow).
- stride_i  in  N_CH×ADDR_W  per-channel per-iteration stride.
- strm_req_o  out  N_CH  request valid per channel.
- strm_addr_o  out  N_CH×ADDR_W  request address.
- strm_len_o  out  LEN_W  request length (latched len).
- strm_ready_i  in  N_CH  request accept.
- strm_done_i  in  N_CH  channel transfer complete pulse.
- eng_start_o  out  1  engine start pulse.
- eng_done_i  in  1  engine done pulse.
- busy_o  out  1  job in progress.
- done_o  out  1  job-complete pulse (to slave for evt).
- iter_o  out  ITER_W  current iteration index.

Behaviour:
- Reset (rst_ni=0 at a clock edge): state IDLE; all outputs 0; counters, masks and address registers 0.
- clear_i: same effect as reset, one cycle. If clear_i and start_i arrive in the same cycle, clear_i wins.
- States: IDLE, LOAD, ISSUE, COMPUTE, DONE.
- IDLE:
  - On start_i, go to LOAD. start_i is ignored in every other state.
- LOAD (1 cycle):
  - Latch nb_iter, len, stride; addr[c] = base_i[c]; iter = 0; clear issued_mask and done_mask.
  - nb_iter=0 → DONE; otherwise → ISSUE.
- ISSUE:
  - strm_req_o[c] = ~issued_mask[c]. A request is held stable until strm_ready_i[c]=1 (valid/ready rules: no drop, no address change while pending).
  - Channels handshake independently; issued_mask[c] is set on accept.
  - When all bits are set (including channels accepted this cycle), the next cycle asserts eng_start_o for 1 cycle and enters COMPUTE.
- done_mask:
  - strm_done_i[c] is captured sticky in any state from ISSUE onward, so an early done during ISSUE is not lost.
  - eng_done_flag is sticky from COMPUTE entry. eng_done_i and strm_done_i outside ISSUE/COMPUTE are ignored.
- COMPUTE:
  - Leave when eng_done_flag and done_mask is all ones; done pulses coinciding with that cycle count.
  - If iter == nb_iter-1 → DONE.
  - Otherwise: iter+1, addr[c] += stride[c] (modulo 2^ADDR_W, wrap silently), clear both masks and the flag, → ISSUE.
- DONE: done_o=1 for exactly one cycle → IDLE.
- busy_o = 1 in every state except IDLE, combinational from state.
- Latency: start_i to first strm_req_o is 2 cycles (LOAD, then ISSUE).
- Iteration counter: iter_o saturates structurally. nb_iter max = 2^ITER_W-1, so there is no counter overflow.

Decomposition:
- Package mmul_parallel_seq_package holds:
  - state enum seq_state_t;
  - N_CH-independent constants;
  - struct seq_ctrl_t (len, nb_iter) for future hwpe_ctrl_slave mapping.
- Sub-module mmul_parallel_chan_agu, instantiated N_CH times via generate:
  - owns addr register, issued bit, done bit, req/ready handshake;
  - controlled by load/advance/clear strobes from the FSM.

Test Plan:
- N_IN=2, N_OUT=1, nb_iter=3, len=16, bases 0x1000/0x2000/0x3000, strides 0x40/0x40/0x10, ready always 1 → addresses per iteration 0x1000/0x2000/0x3000, 0x1040/0x2040/0x3010, 0x1080/0x2080/0x3020; 3 eng_start_o pulses; done_o one cycle after the final COMPUTE exit.
- Backpressure: channel 1 ready held low 5 cycles → req_o[1] and addr stable throughout; eng_start_o only after channel 1 accept; channels 0/2 assert req exactly until their own accept.
- Early done: strm_done_i[2] arrives in ISSUE before eng_start_o, eng_done_i later → iteration completes without a second done.
- nb_iter=0 → no strm_req_o, no eng_start_o; done_o high 2 cycles after start_i.
- Wrap: base 0xFFFF_FFF0, stride 0x20, nb_iter=2 → second address 0x0000_0010.
- clear_i during COMPUTE, coinciding with start_i → IDLE, all outputs 0 next cycle; a fresh start_i afterwards runs a normal job. Same check with rst_ni low mid-ISSUE.

Source files
------------

// File: rtl/mmul_parallel_seq_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mmul_parallel_seq_package
//
// Shared types and constants for the MMUL_PARALLEL job sequencer.
//   - seq_state_t : sequencer FSM state encoding (also exported on the debug
//                   state port of mmul_parallel_seq_fsm)
//   - seq_ctrl_t  : job control word (len, nb_iter) as the register file of
//                   hwpe_ctrl_slave is expected to present it
//   - seq_is_busy : busy decode shared by the top and any future monitors
// Only N_CH-independent items live here; per-channel widths are parameters of
// the modules that use them.
// -----------------------------------------------------------------------------
package mmul_parallel_seq_package;

  localparam int SEQ_STATE_W    = 3;
  localparam int SEQ_ITER_W_DEF = 16;
  localparam int SEQ_LEN_W_DEF  = 16;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_LOAD    = 3'd1,
    SEQ_ISSUE   = 3'd2,
    SEQ_COMPUTE = 3'd3,
    SEQ_DONE    = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_LEN_W_DEF-1:0]  len;
    logic [SEQ_ITER_W_DEF-1:0] nb_iter;
  } seq_ctrl_t;

  function automatic logic seq_is_busy(input seq_state_t s);
    return s != SEQ_IDLE;
  endfunction

endpackage

// File: rtl/mmul_parallel_seq_fsm_chan_agu.sv
// -----------------------------------------------------------------------------
// mmul_parallel_chan_agu
//
// One stream channel of the job sequencer: address generator plus the
// per-iteration request / completion bookkeeping.
//
// Ports
//   clk_i, rst_ni  clock, synchronous active-low reset
//   i_clear        soft clear (same effect as reset)
//   i_load         job start: addr <= i_base, latch i_stride, clear both bits
//   i_advance      next iteration: addr += stride, clear both bits
//   i_issue_en     sequencer is in ISSUE, request may be raised
//   i_done_en      sequencer is in ISSUE or COMPUTE, done pulses are captured
//   i_base         base address of this channel
//   i_stride       per-iteration stride of this channel
//   i_ready        request accept from the streamer
//   i_done         transfer-complete pulse from the streamer
//   o_req          request valid
//   o_addr         request address
//   o_issued_nx    issued bit including an accept in this cycle
//   o_done_nx      done bit including a done pulse in this cycle
//
// Handshake: o_req stays high with o_addr unchanged from the first cycle of
// ISSUE until the cycle in which i_ready is seen high (the accept cycle); it
// is low from the following cycle until the next iteration begins.
// -----------------------------------------------------------------------------
module mmul_parallel_chan_agu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic              i_issue_en,
  input  logic              i_done_en,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic              i_ready,
  input  logic              i_done,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_issued_nx,
  output logic              o_done_nx
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic              r_issued;
  logic              r_done;

  logic              w_accept;
  logic              w_done_hit;

  assign o_req       = i_issue_en & ~r_issued;
  assign w_accept    = o_req & i_ready;
  assign o_issued_nx = r_issued | w_accept;

  // A done pulse arriving while requests are still being issued is kept, so
  // a fast channel cannot lose its completion before the engine starts.
  assign w_done_hit  = i_done_en & i_done;
  assign o_done_nx   = r_done | w_done_hit;

  assign o_addr      = r_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || i_clear) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_issued <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_issued <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_advance) begin
      // Linear stride; overflow wraps modulo 2^ADDR_W.
      r_addr   <= r_addr + r_stride;
      r_issued <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_issued <= o_issued_nx;
      r_done   <= o_done_nx;
    end
  end

endmodule

// File: rtl/mmul_parallel_seq_fsm.sv
// -----------------------------------------------------------------------------
// mmul_parallel_seq_fsm
//
// Multi-channel job sequencer between hwpe_ctrl_slave and the streamer /
// engine. A job runs nb_iter iterations; each iteration issues one request
// per channel (N_IN sources then N_OUT sinks), pulses the engine start once
// every channel has accepted, then waits for the engine done and every
// channel's transfer-complete before advancing.
//
// Ports
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         soft clear, same effect as reset, wins over start_i
//   start_i         job trigger, honoured in IDLE only
//   nb_iter_i       iteration count (0 = empty job)
//   len_i           transfer length per request
//   base_i          per-channel base address, channel c at [c*ADDR_W +: ADDR_W]
//   stride_i        per-channel per-iteration stride, same layout
//   strm_req_o      request valid per channel
//   strm_addr_o     request address per channel, same layout as base_i
//   strm_len_o      latched request length
//   strm_ready_i    request accept per channel
//   strm_done_i     transfer-complete pulse per channel
//   eng_start_o     engine start pulse
//   eng_done_i      engine done pulse
//   busy_o          job in progress (any state but IDLE)
//   done_o          job-complete pulse
//   iter_o          current iteration index
//   dbg_state_o     current FSM state (seq_state_t encoding)
//
// Valid/ready: a channel request (strm_req_o[c], strm_addr_o[c], strm_len_o)
// is raised at the start of ISSUE and held unchanged until strm_ready_i[c] is
// high in the same cycle; that cycle is the transfer. Nothing is withdrawn
// while pending except by reset or clear.
// -----------------------------------------------------------------------------
module mmul_parallel_seq_fsm
  import mmul_parallel_seq_package::*;
#(
  parameter  int N_IN   = 2,
  parameter  int N_OUT  = 1,
  parameter  int ADDR_W = 32,
  parameter  int ITER_W = 16,
  parameter  int LEN_W  = 16,
  localparam int N_CH   = N_IN + N_OUT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ITER_W-1:0]      nb_iter_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic [N_CH*ADDR_W-1:0] base_i,
  input  logic [N_CH*ADDR_W-1:0] stride_i,
  output logic [N_CH-1:0]        strm_req_o,
  output logic [N_CH*ADDR_W-1:0] strm_addr_o,
  output logic [LEN_W-1:0]       strm_len_o,
  input  logic [N_CH-1:0]        strm_ready_i,
  input  logic [N_CH-1:0]        strm_done_i,
  output logic                   eng_start_o,
  input  logic                   eng_done_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ITER_W-1:0]      iter_o,
  output logic [SEQ_STATE_W-1:0] dbg_state_o
);

  localparam logic [ITER_W-1:0] ITER_ONE = 1;
  localparam logic [ITER_W:0]   ITER_ONE_X = 1;

  seq_state_t        r_state;
  seq_state_t        w_state_nx;

  logic [ITER_W-1:0] r_nb_iter;
  logic [ITER_W-1:0] r_iter;
  logic [LEN_W-1:0]  r_len;
  logic              r_eng_flag;
  logic              r_eng_start;

  logic [N_CH-1:0]   w_issued_nx;
  logic [N_CH-1:0]   w_done_nx;
  logic              w_all_issued;
  logic              w_all_done;
  logic              w_eng_done;
  logic              w_exit;
  logic              w_last;

  logic              w_load;
  logic              w_advance;
  logic              w_issue_en;
  logic              w_done_en;

  // Completion terms include pulses arriving this cycle, so a done that
  // coincides with the exit decision is not needed a second time.
  assign w_all_issued = &w_issued_nx;
  assign w_all_done   = &w_done_nx;
  assign w_eng_done   = r_eng_flag | eng_done_i;
  assign w_exit       = (r_state == SEQ_COMPUTE) & w_eng_done & w_all_done;
  // Widened compare avoids nb_iter-1 underflow; COMPUTE is only reached with
  // nb_iter >= 1 anyway.
  assign w_last       = (({1'b0, r_iter} + ITER_ONE_X) == {1'b0, r_nb_iter});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      SEQ_IDLE:    if (start_i) w_state_nx = SEQ_LOAD;
      SEQ_LOAD:    w_state_nx = (nb_iter_i == '0) ? SEQ_DONE : SEQ_ISSUE;
      SEQ_ISSUE:   if (w_all_issued) w_state_nx = SEQ_COMPUTE;
      SEQ_COMPUTE: if (w_exit) w_state_nx = w_last ? SEQ_DONE : SEQ_ISSUE;
      SEQ_DONE:    w_state_nx = SEQ_IDLE;
      default:     w_state_nx = SEQ_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load     = 1'b0;
    w_advance  = 1'b0;
    w_issue_en = 1'b0;
    w_done_en  = 1'b0;
    done_o     = 1'b0;
    busy_o     = seq_is_busy(r_state);
    case (r_state)
      SEQ_LOAD:    w_load = 1'b1;
      SEQ_ISSUE: begin
        w_issue_en = 1'b1;
        w_done_en  = 1'b1;
      end
      SEQ_COMPUTE: begin
        w_done_en = 1'b1;
        w_advance = w_exit & ~w_last;
      end
      SEQ_DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_nb_iter   <= '0;
      r_iter      <= '0;
      r_len       <= '0;
      r_eng_flag  <= 1'b0;
      r_eng_start <= 1'b0;
    end else begin
      // The start pulse lands in the first COMPUTE cycle.
      r_eng_start <= (r_state == SEQ_ISSUE) && w_all_issued;

      if (w_load) begin
        r_nb_iter <= nb_iter_i;
        r_len     <= len_i;
        r_iter    <= '0;
      end else if (w_advance) begin
        r_iter    <= r_iter + ITER_ONE;
      end

      // Engine done is only meaningful once the engine has been started.
      if ((r_state == SEQ_COMPUTE) && !w_exit) begin
        r_eng_flag <= r_eng_flag | eng_done_i;
      end else begin
        r_eng_flag <= 1'b0;
      end
    end
  end

  assign eng_start_o = r_eng_start;
  assign strm_len_o  = r_len;
  assign iter_o      = r_iter;
  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------------------
  // Per-channel address generators
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mmul_parallel_chan_agu #(
      .ADDR_W (ADDR_W)
    ) u_agu (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_clear     (clear_i),
      .i_load      (w_load),
      .i_advance   (w_advance),
      .i_issue_en  (w_issue_en),
      .i_done_en   (w_done_en),
      .i_base      (base_i[c*ADDR_W +: ADDR_W]),
      .i_stride    (stride_i[c*ADDR_W +: ADDR_W]),
      .i_ready     (strm_ready_i[c]),
      .i_done      (strm_done_i[c]),
      .o_req       (strm_req_o[c]),
      .o_addr      (strm_addr_o[c*ADDR_W +: ADDR_W]),
      .o_issued_nx (w_issued_nx[c]),
      .o_done_nx   (w_done_nx[c])
    );
  end

endmodule

// File: tb/tb_mmul_parallel_seq_fsm.sv
module tb_mmul_parallel_seq_fsm;

  localparam int N_CH = 3;
  localparam int AW   = 32;
  localparam int IW   = 16;
  localparam int LW   = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               clear;
  logic               start;
  logic [IW-1:0]      nb_iter;
  logic [LW-1:0]      len;
  logic [N_CH*AW-1:0] base;
  logic [N_CH*AW-1:0] stride;
  logic [N_CH-1:0]    req;
  logic [N_CH*AW-1:0] addr;
  logic [LW-1:0]      slen;
  logic [N_CH-1:0]    ready;
  logic [N_CH-1:0]    sdone;
  logic               eng_start;
  logic               eng_done;
  logic               busy;
  logic               done;
  logic [IW-1:0]      iter;
  logic [2:0]         dbg_state;

  mmul_parallel_seq_fsm #(
    .N_IN(2), .N_OUT(1), .ADDR_W(AW), .ITER_W(IW), .LEN_W(LW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .start_i      (start),
    .nb_iter_i    (nb_iter),
    .len_i        (len),
    .base_i       (base),
    .stride_i     (stride),
    .strm_req_o   (req),
    .strm_addr_o  (addr),
    .strm_len_o   (slen),
    .strm_ready_i (ready),
    .strm_done_i  (sdone),
    .eng_start_o  (eng_start),
    .eng_done_i   (eng_done),
    .busy_o       (busy),
    .done_o       (done),
    .iter_o       (iter),
    .dbg_state_o  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: expected request addresses per channel, in issue order
  // ---------------------------------------------------------------------------
  logic [AW-1:0] exp_q0[$];
  logic [AW-1:0] exp_q1[$];
  logic [AW-1:0] exp_q2[$];
  logic [LW-1:0] exp_len;
  int            exp_nb;

  int            acc_cnt [N_CH];
  int            starts_cnt;
  int            total_starts;
  logic [AW-1:0] last_acc [N_CH];
  logic [N_CH-1:0] prev_pend;
  logic [AW-1:0] prev_addr [N_CH];
  logic          prev_es;
  logic          prev_done;

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      acc_cnt[c]   = 0;
      last_acc[c]  = '0;
      prev_addr[c] = '0;
    end
    starts_cnt   = 0;
    total_starts = 0;
    prev_pend    = '0;
    prev_es      = 1'b0;
    prev_done    = 1'b0;
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin : compare
    logic [AW-1:0] a;
    logic [AW-1:0] e;
    logic          have;
    if (rst_n && busy) begin
      for (int c = 0; c < N_CH; c++) begin
        a = addr[c*AW +: AW];
        // A channel requests at most once per iteration.
        if (req[c]) chk("req_once_per_iter", 64'(acc_cnt[c]), 64'(starts_cnt));
        if (prev_pend[c]) begin
          chk("req_held", 64'(req[c]), 64'd1);
          chk("addr_held", 64'(a), 64'(prev_addr[c]));
        end
        if (req[c] && ready[c]) begin
          have = 1'b0;
          e    = '0;
          case (c)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
          endcase
          chk("req_expected", 64'(have), 64'd1);
          if (have) chk($sformatf("addr_ch%0d", c), 64'(a), 64'(e));
          chk("req_len", 64'(slen), 64'(exp_len));
          acc_cnt[c]++;
          last_acc[c] = a;
        end
        prev_pend[c] = req[c] & ~ready[c];
        prev_addr[c] = a;
      end
      if (eng_start) begin
        for (int c = 0; c < N_CH; c++)
          chk("eng_start_after_accepts", 64'(acc_cnt[c]), 64'(starts_cnt + 1));
        chk("iter_at_start", 64'(iter), 64'(starts_cnt));
        chk("eng_start_one_cycle", 64'(prev_es), 64'd0);
        starts_cnt++;
        total_starts++;
      end
      if (done) begin
        chk("done_one_cycle", 64'(prev_done), 64'd0);
        chk("iters_at_done", 64'(starts_cnt), 64'(exp_nb));
        for (int c = 0; c < N_CH; c++)
          chk("accepts_at_done", 64'(acc_cnt[c]), 64'(exp_nb));
      end
      prev_es   = eng_start;
      prev_done = done;
    end else begin
      for (int c = 0; c < N_CH; c++) acc_cnt[c] = 0;
      starts_cnt = 0;
      prev_pend  = '0;
      prev_es    = 1'b0;
      prev_done  = 1'b0;
      if (!busy) chk("idle_quiet", 64'({req, eng_start, done}), 64'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: streamer / engine responder, one call per clock
  // ---------------------------------------------------------------------------
  int bp_ch;
  int bp_left;
  int eng_lat;
  int eng_cnt;
  bit early_mode;
  bit early_sent;
  bit acc2_prev;

  task automatic tick();
    @(posedge clk);
    #1;
    start    = 1'b0;
    clear    = 1'b0;
    eng_done = 1'b0;
    sdone    = '0;
    if (acc2_prev && early_mode && !early_sent) begin
      sdone[2]   = 1'b1;
      early_sent = 1'b1;
      early_mode = 1'b0;
      chk("early_done_in_issue", 64'(req[1]), 64'd1);
    end
    if (eng_start) begin
      eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        sdone      = early_sent ? 3'b011 : 3'b111;
        early_sent = 1'b0;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      ready[c] = 1'b1;
      if (c == bp_ch && bp_left > 0 && req[c]) begin
        ready[c] = 1'b0;
        bp_left--;
      end
    end
    acc2_prev = req[2] & ready[2];
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] b, input logic [AW-1:0] s);
    base[c*AW +: AW]   = b;
    stride[c*AW +: AW] = s;
  endtask

  task automatic flush_q();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_req"}, 64'(req), 64'd0);
    chk({name, "_addr_lo"}, addr[63:0], 64'd0);
    chk({name, "_addr_hi"}, 64'(addr[95:64]), 64'd0);
    chk({name, "_len"}, 64'(slen), 64'd0);
    chk({name, "_iter"}, 64'(iter), 64'd0);
    chk({name, "_eng_start"}, 64'(eng_start), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
  endtask

  // Model: address k of channel c is base[c] + k*stride[c] modulo 2^AW.
  task automatic begin_job(input int nb, input logic [LW-1:0] l);
    logic [AW-1:0] e;
    exp_nb  = nb;
    exp_len = l;
    nb_iter = IW'(nb);
    len     = l;
    for (int c = 0; c < N_CH; c++) begin
      e = base[c*AW +: AW];
      for (int k = 0; k < nb; k++) begin
        case (c)
          0: exp_q0.push_back(e);
          1: exp_q1.push_back(e);
          default: exp_q2.push_back(e);
        endcase
        e = e + stride[c*AW +: AW];
      end
    end
    tick();
    start = 1'b1;
    tick();
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_no_req", 64'(req), 64'd0);
    tick();
    if (nb == 0) begin
      chk("empty_done_at_2", 64'(done), 64'd1);
      chk("empty_no_req", 64'(req), 64'd0);
    end else begin
      chk("first_req", 64'(req), 64'd7);
      for (int c = 0; c < N_CH; c++)
        chk("first_addr", 64'(addr[c*AW +: AW]), 64'(base[c*AW +: AW]));
      chk("first_len", 64'(slen), 64'(l));
    end
  endtask

  task automatic finish_job(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    tick();
    chk({name, "_back_idle"}, 64'(busy), 64'd0);
    chk({name, "_queue_drained"}, 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
  endtask

  task automatic std_bases();
    set_ch(0, 32'h0000_1000, 32'h40);
    set_ch(1, 32'h0000_2000, 32'h40);
    set_ch(2, 32'h0000_3000, 32'h10);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : main
    int s0;
    int n;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; nb_iter = '0; len = '0;
    base = '0; stride = '0; ready = '1; sdone = '0; eng_done = 1'b0;
    bp_ch = 0; bp_left = 0; eng_lat = 3; eng_cnt = 0;
    early_mode = 1'b0; early_sent = 1'b0; acc2_prev = 1'b0;
    exp_len = '0; exp_nb = 0;

    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_dbg_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-iteration job, no backpressure.
    std_bases();
    s0 = total_starts;
    begin_job(3, 16'd16);
    finish_job("basic");
    chk("basic_starts", 64'(total_starts - s0), 64'd3);
    chk("basic_last_ch0", 64'(last_acc[0]), 64'h1080);
    chk("basic_last_ch1", 64'(last_acc[1]), 64'h2080);
    chk("basic_last_ch2", 64'(last_acc[2]), 64'h3020);

    // Backpressure on channel 1 for five cycles.
    bp_ch = 1; bp_left = 5;
    s0 = total_starts;
    begin_job(2, 16'd8);
    finish_job("bp");
    chk("bp_consumed", 64'(bp_left), 64'd0);
    chk("bp_starts", 64'(total_starts - s0), 64'd2);

    // Early stream done on channel 2 while channel 1 is still pending.
    bp_ch = 1; bp_left = 5; early_mode = 1'b1;
    s0 = total_starts;
    begin_job(2, 16'd4);
    finish_job("early");
    chk("early_fired", 64'(early_mode), 64'd0);
    chk("early_starts", 64'(total_starts - s0), 64'd2);

    // Empty job.
    s0 = total_starts;
    begin_job(0, 16'd16);
    finish_job("empty");
    chk("empty_starts", 64'(total_starts - s0), 64'd0);

    // Address wrap.
    set_ch(0, 32'hFFFF_FFF0, 32'h20);
    begin_job(2, 16'd16);
    finish_job("wrap");
    chk("wrap_second_addr", 64'(last_acc[0]), 64'h10);

    // Soft clear in COMPUTE together with start.
    std_bases();
    eng_lat = 8;
    begin_job(3, 16'd16);
    n = 0;
    while (!eng_start && n < 100) begin
      tick();
      n++;
    end
    chk("clr_saw_eng_start", 64'(eng_start), 64'd1);
    tick();
    tick();
    clear = 1'b1;
    start = 1'b1;
    tick();
    eng_cnt = 0;
    chk_all_zero("clear");
    tick();
    chk("clear_beats_start", 64'(busy), 64'd0);
    flush_q();
    eng_lat = 3;
    begin_job(2, 16'd16);
    finish_job("after_clear");

    // Reset in the middle of ISSUE.
    bp_ch = 1; bp_left = 20;
    begin_job(2, 16'd16);
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    bp_left = 0; eng_cnt = 0; early_sent = 1'b0;
    flush_q();
    tick();
    begin_job(2, 16'd16);
    finish_job("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
